tank_move_controller: RTL and testbench
=======================================

# tank_move_controller

Per-tank motion controller that sits directly upstream of the tank square/bitmap drawing stage. Once per video frame it samples the player's direction keys and the frame's collision flag, and updates the tank's position and facing. Its outputs `topLeftX`, `topLeftY` and `tankDir` feed the drawing stage as stable, registered values.

## Interface
- `INIT_X`, default 304: reset X of the top-left corner.
- `INIT_Y`, default 400: reset Y of the top-left corner.
- `SPEED`, default 2: pixels moved per frame (1..15).
- `OBJECT_WIDTH_X`, default 32: tank width, also used as its height.
- `SCREEN_W`, default 640: horizontal limit.
- `SCREEN_H`, default 480: vertical limit.
- `GRID`, default 16: snap granularity; power of two. Used only with the configuration macro.
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `keyUp`, `keyRight`, `keyDown`, `keyLeft` in 1 each: level key inputs, already debounced.
- `collision` in 1: high on any cycle where this tank's drawing overlaps a solid object.
- `topLeftX` out 11: tank top-left X.
- `topLeftY` out 11: tank top-left Y.
- `tankDir` out 2: facing. 00 up, 01 right, 10 down, 11 left.
- `moving` out 1: high while the tank moved in the last frame update.

## Operation
**Key priority.** The requested direction is the highest-priority pressed key. Priority order: up > right > down > left. No key pressed means no request.

**States.** The FSM has three states: `IDLE`, `MOVE`, `BLOCKED`. All transitions happen only on the cycle after `startOfFrame`.

**Collision latch.**
- `colFlag` sets on any cycle where `collision` = 1.
- It is consumed and cleared at `startOfFrame`.
- `collision` in the same cycle as `startOfFrame` counts for the frame that is ending.

**Frame update sequence.**
1. If `colFlag` is set and the state was `MOVE`:
   - restore the saved previous position;
   - go to `BLOCKED`, recording `blockDir` = `tankDir`;
   - skip the remaining steps this frame.
2. If there is no request: go to `IDLE`. Position is unchanged.
3. If the request differs from `tankDir` (a turn):
   - update `tankDir` only; no displacement this frame;
   - next state is `MOVE`;
   - `BLOCKED` is also exited.
4. If the request equals `tankDir`:
   - in `BLOCKED` with request = `blockDir`: stay `BLOCKED`, no motion;
   - otherwise: save the current position as previous, step `SPEED` pixels in `tankDir`, and stay in or enter `MOVE`.

**Arithmetic and clamping.**
- Compute in 12-bit signed.
- Clamp X to [0, `SCREEN_W` − `OBJECT_WIDTH_X`] and Y to [0, `SCREEN_H` − `OBJECT_WIDTH_X`].
- A step that clamps still counts as movement only if the position actually changed.

**`moving` output.** `moving` = 1 exactly when position changed in the last update.

**Releasing all keys** while in `BLOCKED` returns the FSM to `IDLE`.

## Timing
**Reset values.**
- `topLeftX` = `INIT_X`, `topLeftY` = `INIT_Y`.
- `tankDir` = 00.
- `moving` = 0, `colFlag` = 0.
- State = `IDLE`. Saved previous position = init values.

**Update latency.** Outputs change exactly 1 cycle after `startOfFrame` and hold for the rest of the frame. The drawing stage therefore sees constant coordinates for the whole visible frame.

**Key sampling.** Keys are sampled only on the `startOfFrame` cycle.

**Reset mid-frame.** Reset asserted mid-frame returns all outputs to reset values immediately, since reset is asynchronous. The first update after reset release needs a fresh `startOfFrame`.

**Back-to-back pulses.** Consecutive `startOfFrame` pulses are legal. Each one performs one update.

## Configuration
Macro: `TANK_GRID_ALIGN_EN`.
- **Defined:** on a turn (step 3), the coordinate perpendicular to the new direction is rounded to the nearest multiple of `GRID`, with halves rounded up, then clamped.
  - New direction up or down: X is snapped.
  - New direction left or right: Y is snapped.
- **Undefined:** turns change only `tankDir`; position is untouched.

## Structure
**Package `tank_pkg`** contains:
- `dir_t` enum (`DIR_UP`, `DIR_RIGHT`, `DIR_DOWN`, `DIR_LEFT` = 0..3);
- `move_state_t` enum (`IDLE`, `MOVE`, `BLOCKED`);
- shared constants `SCREEN_W` and `SCREEN_H`, reused by the drawing stages.

**Sub-module `tank_dir_encoder`:** combinational priority encoder from the four key bits to `{valid, dir_t}`.

## Test plan
1. **Reset:** reset, then release. Expect X = 304, Y = 400, dir = 00, `moving` = 0. Pulse `startOfFrame` with no keys: outputs unchanged, state `IDLE`.
2. **Step and priority:**
   - Hold `keyUp` for 3 frames: Y goes 400 → 398 → 396 → 394, X stays 304, `moving` = 1.
   - Press `keyUp` and `keyLeft` together: up wins.
3. **Turn:** at dir = up, hold `keyRight`.
   - Frame 1: dir = 01, X and Y unchanged, `moving` = 0.
   - Frame 2: X = 306.
   - With `TANK_GRID_ALIGN_EN` and Y = 394: Y snaps to 400 on frame 1.
4. **Collision:** moving right from X = 306 to 308, pulse `collision` mid-frame.
   - Next frame: X = 306, state `BLOCKED`.
   - Holding right: X stays 306.
   - Pressing down: dir = 10, state `MOVE`.
5. **Clamp:** X = 607, hold right with `SPEED` = 2.
   - X = 608, then stays 608 (640 − 32) with `moving` = 0.
   - At Y = 1 moving up: Y = 0.
6. **Edge timing:** assert `collision` on the same cycle as `startOfFrame` while in `MOVE`, expecting a revert. Assert `resetN` low mid-frame: outputs return to reset values the same cycle.

Source files
------------

// File: rtl/tank_pkg.sv
// tank_pkg: types and constants shared by the tank motion and drawing stages.
//   dir_t        - facing / requested direction (00 up, 01 right, 10 down, 11 left)
//   move_state_t - motion FSM states
//   SCREEN_W/H   - visible screen size in pixels
//   clamp_coord  - saturate a 12-bit signed coordinate into [0, hi]
package tank_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    BLOCKED = 2'd2
  } move_state_t;

  function automatic logic [10:0] clamp_coord(input logic signed [11:0] v,
                                              input logic signed [11:0] hi);
    if (v < 12'sd0)   return 11'd0;
    else if (v > hi)  return hi[10:0];
    else              return v[10:0];
  endfunction

endpackage

// File: rtl/tank_dir_encoder.sv
// tank_dir_encoder: priority encoder from the four direction keys to a
// direction request. Priority up > right > down > left; valid=0 when no key.
//   key_up/key_right/key_down/key_left - debounced key levels
//   valid                              - some key is pressed
//   dir                                - highest-priority pressed direction
module tank_dir_encoder
  import tank_pkg::*;
(
  input  logic key_up,
  input  logic key_right,
  input  logic key_down,
  input  logic key_left,
  output logic valid,
  output dir_t dir
);

  always_comb begin
    valid = 1'b1;
    dir   = DIR_UP;
    if (key_up)         dir = DIR_UP;
    else if (key_right) dir = DIR_RIGHT;
    else if (key_down)  dir = DIR_DOWN;
    else if (key_left)  dir = DIR_LEFT;
    else                valid = 1'b0;
  end

endmodule

// File: rtl/tank_move_controller.sv
// tank_move_controller: once-per-frame tank motion update feeding the tank
// drawing stage. Keys and the latched collision flag are consumed on the
// startOfFrame cycle; registered outputs change on the following cycle and
// hold for the rest of the frame.
//   clk, resetN          - clock, asynchronous active-low reset
//   startOfFrame         - one-cycle frame pulse
//   keyUp/Right/Down/Left- debounced key levels
//   collision            - tank drawing overlaps a solid object this cycle
//   topLeftX/topLeftY    - tank top-left corner
//   tankDir              - facing (00 up, 01 right, 10 down, 11 left)
//   moving               - position changed in the last frame update
// Optional feature: define TANK_GRID_ALIGN_EN to snap the perpendicular
// coordinate to a GRID multiple whenever the tank turns.
module tank_move_controller #(
  parameter int INIT_X         = 304,
  parameter int INIT_Y         = 400,
  parameter int SPEED          = 2,
  parameter int OBJECT_WIDTH_X = 32,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int GRID           = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        keyUp,
  input  logic        keyRight,
  input  logic        keyDown,
  input  logic        keyLeft,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  tankDir,
  output logic        moving
);
  import tank_pkg::*;

  localparam logic signed [11:0] MAX_X = 12'(SCREEN_W - OBJECT_WIDTH_X);
  localparam logic signed [11:0] MAX_Y = 12'(SCREEN_H - OBJECT_WIDTH_X);
  localparam logic signed [11:0] STEP  = 12'(SPEED);

  // Snapping relies on masking, so GRID must be a power of two.
  if ((GRID <= 0) || ((GRID & (GRID - 1)) != 0)) begin : g_bad_grid
    $error("GRID must be a power of two");
  end

  logic        req_valid;
  dir_t        req_dir;

  tank_dir_encoder u_enc (
    .key_up   (keyUp),
    .key_right(keyRight),
    .key_down (keyDown),
    .key_left (keyLeft),
    .valid    (req_valid),
    .dir      (req_dir)
  );

  logic [10:0] x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
  dir_t        dir_q, dir_d, blk_dir_q, blk_dir_d;
  move_state_t state_q, state_d;
  logic        moving_q, moving_d, col_flag_q, col_flag_d;
  logic        col_now;
  logic signed [11:0] sx, sy;

`ifdef TANK_GRID_ALIGN_EN
  localparam logic [11:0] GHALF = 12'(GRID / 2);
  localparam logic [11:0] GMASK = ~12'(GRID - 1);
  logic signed [11:0] snap_x, snap_y;
  // Round half up: add half a cell, then drop the low bits.
  assign snap_x = signed'(({1'b0, x_q} + GHALF) & GMASK);
  assign snap_y = signed'(({1'b0, y_q} + GHALF) & GMASK);
`endif

  assign sx = signed'({1'b0, x_q});
  assign sy = signed'({1'b0, y_q});

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    px_d       = px_q;
    py_d       = py_q;
    dir_d      = dir_q;
    blk_dir_d  = blk_dir_q;
    state_d    = state_q;
    moving_d   = moving_q;
    // A collision on the startOfFrame cycle belongs to the frame just ending.
    col_now    = col_flag_q | collision;
    col_flag_d = col_now;
    if (startOfFrame) begin
      col_flag_d = 1'b0;
      if (col_now && state_q == MOVE) begin
        x_d       = px_q;
        y_d       = py_q;
        state_d   = BLOCKED;
        blk_dir_d = dir_q;
      end else if (!req_valid) begin
        state_d = IDLE;
      end else if (req_dir != dir_q) begin
        dir_d   = req_dir;
        state_d = MOVE;
`ifdef TANK_GRID_ALIGN_EN
        if (req_dir == DIR_UP || req_dir == DIR_DOWN) x_d = clamp_coord(snap_x, MAX_X);
        else                                          y_d = clamp_coord(snap_y, MAX_Y);
`endif
      end else if (!(state_q == BLOCKED && req_dir == blk_dir_q)) begin
        px_d    = x_q;
        py_d    = y_q;
        state_d = MOVE;
        case (dir_q)
          DIR_UP:    y_d = clamp_coord(sy - STEP, MAX_Y);
          DIR_RIGHT: x_d = clamp_coord(sx + STEP, MAX_X);
          DIR_DOWN:  y_d = clamp_coord(sy + STEP, MAX_Y);
          default:   x_d = clamp_coord(sx - STEP, MAX_X);
        endcase
      end
      moving_d = (x_d != x_q) || (y_d != y_q);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      x_q        <= 11'(INIT_X);
      y_q        <= 11'(INIT_Y);
      px_q       <= 11'(INIT_X);
      py_q       <= 11'(INIT_Y);
      dir_q      <= DIR_UP;
      blk_dir_q  <= DIR_UP;
      state_q    <= IDLE;
      moving_q   <= 1'b0;
      col_flag_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      px_q       <= px_d;
      py_q       <= py_d;
      dir_q      <= dir_d;
      blk_dir_q  <= blk_dir_d;
      state_q    <= state_d;
      moving_q   <= moving_d;
      col_flag_q <= col_flag_d;
    end
  end

  assign topLeftX = x_q;
  assign topLeftY = y_q;
  assign tankDir  = dir_q;
  assign moving   = moving_q;

endmodule

// File: tb/tb_tank_move_controller.sv
// tb_tank_move_controller: directed self-checking bench for the tank motion
// controller. A second instance placed near the screen edge exercises clamping.
module tb_tank_move_controller;
  import tank_pkg::*;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof = 1'b0, coll = 1'b0;
  logic ku = 1'b0, kr = 1'b0, kd = 1'b0, kl = 1'b0;
  logic [10:0] x_o, y_o, cx_o, cy_o;
  logic [1:0]  d_o, cd_o;
  logic        m_o, cm_o;

  int n_pass = 0, n_total = 0;
  int ex, ey;

  always #5 clk = ~clk;

  tank_move_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof),
    .keyUp(ku), .keyRight(kr), .keyDown(kd), .keyLeft(kl), .collision(coll),
    .topLeftX(x_o), .topLeftY(y_o), .tankDir(d_o), .moving(m_o)
  );

  tank_move_controller #(.INIT_X(607), .INIT_Y(1)) dut_c (
    .clk(clk), .resetN(resetN), .startOfFrame(sof),
    .keyUp(ku), .keyRight(kr), .keyDown(kd), .keyLeft(kl), .collision(coll),
    .topLeftX(cx_o), .topLeftY(cy_o), .tankDir(cd_o), .moving(cm_o)
  );

  // k = {up, right, down, left}
  task automatic frame(input logic [3:0] k, input bit c_mid, input bit c_sof);
    @(negedge clk); {ku, kr, kd, kl} = k; sof = 1'b1; coll = c_sof;
    @(negedge clk); sof = 1'b0; coll = c_mid;
    @(negedge clk); coll = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (x_o !== 11'd304) $display("FAIL reset_x got %0d want 304", x_o); else n_pass++;
    n_total++; if (y_o !== 11'd400) $display("FAIL reset_y got %0d want 400", y_o); else n_pass++;
    n_total++; if (d_o !== 2'd0) $display("FAIL reset_dir got %0d want 0", d_o); else n_pass++;
    n_total++; if (m_o !== 1'b0) $display("FAIL reset_moving got %0d want 0", m_o); else n_pass++;
    n_total++; if (dut.col_flag_q !== 1'b0) $display("FAIL reset_colflag got %0d want 0", dut.col_flag_q); else n_pass++;
    resetN = 1'b1;
    frame(4'b0000, 0, 0);
    n_total++; if (x_o !== 11'd304 || y_o !== 11'd400) $display("FAIL idle_pos got %0d,%0d want 304,400", x_o, y_o); else n_pass++;
    n_total++; if (m_o !== 1'b0) $display("FAIL idle_moving got %0d want 0", m_o); else n_pass++;
    n_total++; if (dut.state_q !== IDLE) $display("FAIL idle_state got %0d want %0d", dut.state_q, IDLE); else n_pass++;
  endtask

  task automatic test_step;
    for (int i = 1; i <= 3; i++) begin
      frame(4'b1000, 0, 0);
      n_total++; if (y_o !== 11'(400 - 2 * i)) $display("FAIL step_y%0d got %0d want %0d", i, y_o, 400 - 2 * i); else n_pass++;
      n_total++; if (x_o !== 11'd304 || m_o !== 1'b1) $display("FAIL step_x_mv%0d got %0d/%0d want 304/1", i, x_o, m_o); else n_pass++;
    end
    // up + left together: up wins; also check update latency and hold
    @(negedge clk); {ku, kr, kd, kl} = 4'b1001; sof = 1'b1;
    n_total++; if (y_o !== 11'd394) $display("FAIL early_update got %0d want 394", y_o); else n_pass++;
    @(negedge clk); sof = 1'b0;
    n_total++; if (y_o !== 11'd392 || d_o !== 2'd0) $display("FAIL priority got y%0d d%0d want y392 d0", y_o, d_o); else n_pass++;
    repeat (4) @(negedge clk);
    n_total++; if (y_o !== 11'd392 || x_o !== 11'd304) $display("FAIL hold got %0d,%0d want 304,392", x_o, y_o); else n_pass++;
    ex = 304; ey = 392;
  endtask

  task automatic test_turn;
    frame(4'b0100, 0, 0);
`ifdef TANK_GRID_ALIGN_EN
    ey = 400;
`endif
    n_total++; if (d_o !== 2'd1) $display("FAIL turn_dir got %0d want 1", d_o); else n_pass++;
    n_total++; if (x_o !== 11'(ex) || y_o !== 11'(ey)) $display("FAIL turn_pos got %0d,%0d want %0d,%0d", x_o, y_o, ex, ey); else n_pass++;
`ifndef TANK_GRID_ALIGN_EN
    n_total++; if (m_o !== 1'b0) $display("FAIL turn_moving got %0d want 0", m_o); else n_pass++;
`endif
    n_total++; if (dut.state_q !== MOVE) $display("FAIL turn_state got %0d want %0d", dut.state_q, MOVE); else n_pass++;
    frame(4'b0100, 0, 0);
    n_total++; if (x_o !== 11'd306 || m_o !== 1'b1) $display("FAIL turn_step got %0d/%0d want 306/1", x_o, m_o); else n_pass++;
  endtask

  task automatic test_collision;
    frame(4'b0100, 1, 0);
    n_total++; if (x_o !== 11'd308) $display("FAIL col_pre got %0d want 308", x_o); else n_pass++;
    frame(4'b0100, 0, 0);
    n_total++; if (x_o !== 11'd306) $display("FAIL col_revert got %0d want 306", x_o); else n_pass++;
    n_total++; if (dut.state_q !== BLOCKED) $display("FAIL col_state got %0d want %0d", dut.state_q, BLOCKED); else n_pass++;
    frame(4'b0100, 0, 0);
    n_total++; if (x_o !== 11'd306 || m_o !== 1'b0) $display("FAIL blocked_hold got %0d/%0d want 306/0", x_o, m_o); else n_pass++;
    n_total++; if (dut.state_q !== BLOCKED) $display("FAIL blocked_state got %0d want %0d", dut.state_q, BLOCKED); else n_pass++;
    frame(4'b0010, 0, 0);
    ex = 306;
`ifdef TANK_GRID_ALIGN_EN
    ex = 304;
`endif
    n_total++; if (d_o !== 2'd2 || dut.state_q !== MOVE) $display("FAIL unblock got d%0d s%0d want d2 s%0d", d_o, dut.state_q, MOVE); else n_pass++;
    n_total++; if (x_o !== 11'(ex) || y_o !== 11'(ey)) $display("FAIL unblock_pos got %0d,%0d want %0d,%0d", x_o, y_o, ex, ey); else n_pass++;
    frame(4'b0000, 0, 0);
    n_total++; if (dut.state_q !== IDLE) $display("FAIL release_state got %0d want %0d", dut.state_q, IDLE); else n_pass++;
  endtask

  task automatic test_edge;
    frame(4'b0010, 0, 0);
    n_total++; if (y_o !== 11'(ey + 2)) $display("FAIL edge_step got %0d want %0d", y_o, ey + 2); else n_pass++;
    frame(4'b0010, 0, 1);
    n_total++; if (y_o !== 11'(ey)) $display("FAIL sof_col_revert got %0d want %0d", y_o, ey); else n_pass++;
    n_total++; if (dut.state_q !== BLOCKED) $display("FAIL sof_col_state got %0d want %0d", dut.state_q, BLOCKED); else n_pass++;
    frame(4'b0000, 0, 0);
    n_total++; if (dut.state_q !== IDLE) $display("FAIL blocked_release got %0d want %0d", dut.state_q, IDLE); else n_pass++;
    // back-to-back pulses: turn left, then step left
    @(negedge clk); {ku, kr, kd, kl} = 4'b0001; sof = 1'b1;
    @(negedge clk);
    n_total++; if (d_o !== 2'd3 || x_o !== 11'(ex)) $display("FAIL b2b_first got d%0d x%0d want d3 x%0d", d_o, x_o, ex); else n_pass++;
    @(negedge clk); sof = 1'b0;
    n_total++; if (x_o !== 11'(ex - 2) || m_o !== 1'b1) $display("FAIL b2b_second got x%0d m%0d want x%0d m1", x_o, m_o, ex - 2); else n_pass++;
    repeat (2) @(negedge clk);
    // asynchronous reset mid-frame
    resetN = 1'b0; #1;
    n_total++; if (x_o !== 11'd304 || y_o !== 11'd400) $display("FAIL async_rst_pos got %0d,%0d want 304,400", x_o, y_o); else n_pass++;
    n_total++; if (d_o !== 2'd0 || m_o !== 1'b0) $display("FAIL async_rst_dm got d%0d m%0d want d0 m0", d_o, m_o); else n_pass++;
    @(negedge clk); resetN = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (x_o !== 11'd304 || y_o !== 11'd400) $display("FAIL no_sof_update got %0d,%0d want 304,400", x_o, y_o); else n_pass++;
  endtask

  task automatic test_clamp;
    resetN = 1'b0;
    @(negedge clk); resetN = 1'b1;
    frame(4'b1000, 0, 0);
    n_total++; if (cy_o !== 11'd0 || cm_o !== 1'b1) $display("FAIL clamp_y got %0d/%0d want 0/1", cy_o, cm_o); else n_pass++;
    frame(4'b1000, 0, 0);
    n_total++; if (cy_o !== 11'd0 || cm_o !== 1'b0) $display("FAIL clamp_y_hold got %0d/%0d want 0/0", cy_o, cm_o); else n_pass++;
    frame(4'b0100, 0, 0);
    n_total++; if (cd_o !== 2'd1 || cx_o !== 11'd607) $display("FAIL clamp_turn got d%0d x%0d want d1 x607", cd_o, cx_o); else n_pass++;
    frame(4'b0100, 0, 0);
    n_total++; if (cx_o !== 11'd608 || cm_o !== 1'b1) $display("FAIL clamp_x got %0d/%0d want 608/1", cx_o, cm_o); else n_pass++;
    frame(4'b0100, 0, 0);
    n_total++; if (cx_o !== 11'd608 || cm_o !== 1'b0) $display("FAIL clamp_x_hold got %0d/%0d want 608/0", cx_o, cm_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_step();
    test_turn();
    test_collision();
    test_edge();
    test_clamp();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
